// File: rtl/mem_client_port.sv
// mem_client_port: requester-side port for one device slot of the three-device
// memory arbiter. Accepts single-word reads/writes and multi-word read bursts
// from the core, drives the arbiter request lines, waits for do_ack and returns
// one response word per ack.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req, req_we, req_addr, req_wdata, req_len : core request (accepted when req_ready)
//   req_ready, busy     : decoded from the state register
//   rsp_valid, rsp_data, rsp_last, rsp_err    : registered response, one pulse per word
//   mem_en, mem_burst_en, mem_addr, mem_di, mem_we : registered lines to the arbiter
//   do_ack, mem_do      : this device's ack bit and shared RAM read data
//
// Optional feature: define MEM_CLIENT_TIMEOUT_EN to abort a request that sees no
// ack for TIMEOUT_CYCLES cycles (response flagged with rsp_err). Without it,
// rsp_err is tied to 0 and REQ waits indefinitely.

module mem_client_port #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_burst_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_we,
  input  logic              do_ack,
  input  logic [DATA_W-1:0] mem_do
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q;
  logic               mem_en_q;
  logic               mem_burst_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_di_q;
  logic               mem_we_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_last_q;
  logic [LEN_W-1:0]   rem_q;

  // Effective read length: a zero length field still means one word.
  logic [LEN_W-1:0]   len_eff_d;
  assign len_eff_d = (req_len == '0) ? LEN_W'(1) : req_len;

`ifdef MEM_CLIENT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign rsp_err = 1'b0;
`endif

  // Control FSM with all arbiter-side and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_en_q       <= 1'b0;
      mem_burst_en_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_di_q       <= '0;
      mem_we_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_last_q     <= 1'b0;
      rem_q          <= '0;
`ifdef MEM_CLIENT_TIMEOUT_EN
      tmo_q          <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      // Response signals are single-cycle pulses.
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef MEM_CLIENT_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q        <= REQ;
            mem_en_q       <= 1'b1;
            mem_addr_q     <= req_addr;
            mem_we_q       <= req_we;
            mem_di_q       <= req_we ? req_wdata : '0;
            mem_burst_en_q <= !req_we && (len_eff_d > LEN_W'(1));
            rem_q          <= req_we ? LEN_W'(1) : len_eff_d;
`ifdef MEM_CLIENT_TIMEOUT_EN
            tmo_q          <= '0;
`endif
          end
        end

        REQ: begin
          if (do_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mem_we_q ? '0 : mem_do;
            rem_q       <= rem_q - LEN_W'(1);
`ifdef MEM_CLIENT_TIMEOUT_EN
            tmo_q       <= '0;
`endif
            if (rem_q == LEN_W'(1)) begin
              rsp_last_q     <= 1'b1;
              mem_en_q       <= 1'b0;
              mem_burst_en_q <= 1'b0;
              mem_we_q       <= 1'b0;
              mem_addr_q     <= '0;
              mem_di_q       <= '0;
              state_q        <= GAP;
            end else begin
              // Address wraps naturally at 2^ADDR_W.
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
`ifdef MEM_CLIENT_TIMEOUT_EN
          else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Last allowed REQ cycle passed without ack: abort with error.
            rsp_valid_q    <= 1'b1;
            rsp_last_q     <= 1'b1;
            rsp_err_q      <= 1'b1;
            mem_en_q       <= 1'b0;
            mem_burst_en_q <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_di_q       <= '0;
            rem_q          <= '0;
            tmo_q          <= '0;
            state_q        <= GAP;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
`endif
        end

        // One released cycle so the arbiter sees mem_en drop.
        GAP: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_last     = rsp_last_q;
  assign mem_en       = mem_en_q;
  assign mem_burst_en = mem_burst_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_di       = mem_di_q;
  assign mem_we       = mem_we_q;

endmodule

// File: tb/tb_mem_client_port.sv
// Directed bench for mem_client_port: stimulus drives the core and arbiter
// sides, expected responses go into a queue and are popped when rsp_valid fires.

module tb_mem_client_port;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              busy;
  logic              mem_en;
  logic              mem_burst_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic              mem_we;
  logic              do_ack;
  logic [DATA_W-1:0] mem_do;

  mem_client_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_len(req_len), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .busy(busy),
    .mem_en(mem_en), .mem_burst_en(mem_burst_en), .mem_addr(mem_addr),
    .mem_di(mem_di), .mem_we(mem_we), .do_ack(do_ack), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic l, input logic e);
    rsp_t r;
    r.data = d;
    r.last = l;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic [LEN_W-1:0] len);
    req       = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_len   = len;
    tick();
    req       = 1'b0;
  endtask

  // Response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_last", 64'(rsp_last), 64'(e.last));
        check("rsp_err",  64'(rsp_err),  64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] ea;
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; do_ack = 1'b0; mem_do = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    tick();

    // Single read, ack on the 4th REQ cycle
    issue(1'b0, 10'h010, 32'h0, 4'd1);
    check("rd_ready_busy", 64'(req_ready), 64'd0);
    check("rd_we", 64'(mem_we), 64'd0);
    check("rd_di", 64'(mem_di), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("rd_en_hold", 64'(mem_en), 64'd1);
      check("rd_addr_hold", 64'(mem_addr), 64'h010);
      check("rd_burst", 64'(mem_burst_en), 64'd0);
      tick();
    end
    check("rd_en_c4", 64'(mem_en), 64'd1);
    do_ack = 1'b1; mem_do = 32'hDEADBEEF;
    push(32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    do_ack = 1'b0;
    check("rd_gap_en", 64'(mem_en), 64'd0);
    check("rd_gap_busy", 64'(busy), 64'd1);
    check("rd_gap_ready", 64'(req_ready), 64'd0);
    tick();
    check("rd_idle_ready", 64'(req_ready), 64'd1);

    // Write ignores req_len; response data is 0
    issue(1'b1, 10'h3FF, 32'h12345678, 4'd7);
    check("wr_en", 64'(mem_en), 64'd1);
    check("wr_we", 64'(mem_we), 64'd1);
    check("wr_di", 64'(mem_di), 64'h12345678);
    check("wr_addr", 64'(mem_addr), 64'h3FF);
    check("wr_burst", 64'(mem_burst_en), 64'd0);
    do_ack = 1'b1; mem_do = 32'hAAAA5555;
    push(32'h0, 1'b1, 1'b0);
    tick();
    do_ack = 1'b0;
    check("wr_done_en", 64'(mem_en), 64'd0);
    check("wr_done_we", 64'(mem_we), 64'd0);
    check("wr_done_di", 64'(mem_di), 64'd0);
    tick();

    // Burst of 4 wrapping the top of the address space, back-to-back acks
    issue(1'b0, 10'h3FE, 32'h0, 4'd4);
    ea = 10'h3FE;
    for (int i = 0; i < 4; i++) begin
      check("bw_addr", 64'(mem_addr), 64'(ea));
      check("bw_en", 64'(mem_en), 64'd1);
      check("bw_burst", 64'(mem_burst_en), 64'd1);
      do_ack = 1'b1; mem_do = 32'h1000 + 32'(i);
      push(32'h1000 + 32'(i), (i == 3), 1'b0);
      ea = ea + 10'd1;
      tick();
    end
    do_ack = 1'b0;
    check("bw_end_en", 64'(mem_en), 64'd0);
    check("bw_end_burst", 64'(mem_burst_en), 64'd0);
    check("bw_end_addr", 64'(mem_addr), 64'd0);
    tick();

    // Stale ack while IDLE is ignored
    do_ack = 1'b1; mem_do = 32'h00000BAD;
    tick();
    do_ack = 1'b0;
    check("stale_ready", 64'(req_ready), 64'd1);
    check("stale_en", 64'(mem_en), 64'd0);

    // Stalled read: ack after 10 cycles, req during busy ignored
    issue(1'b0, 10'h155, 32'h0, 4'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        req = 1'b1; req_we = 1'b1; req_addr = 10'h2AA; req_wdata = 32'h55AA55AA;
      end
      check("stall_en", 64'(mem_en), 64'd1);
      check("stall_addr", 64'(mem_addr), 64'h155);
      check("stall_we", 64'(mem_we), 64'd0);
      tick();
    end
    req = 1'b0;
    do_ack = 1'b1; mem_do = 32'hCAFEF00D;
    push(32'hCAFEF00D, 1'b1, 1'b0);
    tick();
    do_ack = 1'b0;
    check("stall_gap_en", 64'(mem_en), 64'd0);
    tick();
    check("stall_idle", 64'(req_ready), 64'd1);

    // Zero length read behaves as a single word
    issue(1'b0, 10'h000, 32'h0, 4'd0);
    check("len0_burst", 64'(mem_burst_en), 64'd0);
    do_ack = 1'b1; mem_do = 32'h0F0F0F0F;
    push(32'h0F0F0F0F, 1'b1, 1'b0);
    tick();
    do_ack = 1'b0;
    check("len0_en", 64'(mem_en), 64'd0);
    tick();

    // Reset in the middle of an 8-word burst
    issue(1'b0, 10'h020, 32'h0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      do_ack = 1'b1; mem_do = 32'h2000 + 32'(i);
      push(32'h2000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("mid_addr", 64'(mem_addr), 64'h023);
    reset = 1'b1;
    tick();
    check("rst_mid_en", 64'(mem_en), 64'd0);
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    reset = 1'b0; do_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_mid_idle_en", 64'(mem_en), 64'd0);

`ifdef MEM_CLIENT_TIMEOUT_EN
    // No ack: abort after 64 REQ cycles
    issue(1'b0, 10'h040, 32'h0, 4'd1);
    for (int i = 0; i < 64; i++) begin
      check("tmo_en", 64'(mem_en), 64'd1);
      if (i == 63) push(32'h0, 1'b1, 1'b1);
      tick();
    end
    check("tmo_abort_en", 64'(mem_en), 64'd0);
    check("tmo_abort_busy", 64'(busy), 64'd1);
    tick();
    check("tmo_idle", 64'(req_ready), 64'd1);

    // Ack on the 64th cycle wins over the timeout
    issue(1'b0, 10'h041, 32'h0, 4'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        do_ack = 1'b1; mem_do = 32'h64646464;
        push(32'h64646464, 1'b1, 1'b0);
      end
      tick();
    end
    do_ack = 1'b0;
    check("tmo_race_en", 64'(mem_en), 64'd0);
    tick();
`endif

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_client_port.md
Name: mem_client_port

Overview:
Requester-side port that lets one device (fetch unit, load/store unit, DMA) talk to the three-device memory arbiter through one device slot. It accepts single-word read/write requests and multi-word read bursts from the core side. It drives the device's mem_en/burst_en/addr/di/we lines, waits for the device's do_ack bit and returns read data word by word. One instance per device slot.

Parameters:
ADDR_W, 10, word address width (matches RAM depth 1024)
DATA_W, 32, data word width
LEN_W, 4, burst length field width; max burst 2^LEN_W-1 words
TIMEOUT_CYCLES, 64, cycles without ack before abort (used only with MEM_CLIENT_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
req  in  1  core request strobe
req_we  in  1  1=write (single word), 0=read
req_addr  in  ADDR_W  start word address
req_wdata  in  DATA_W  write data
req_len  in  LEN_W  read burst length in words; 0 treated as 1; ignored for writes (forced 1)
req_ready  out  1  high in IDLE only; request accepted on posedge with req&&req_ready
rsp_valid  out  1  one-cycle pulse per completed word
rsp_data  out  DATA_W  read word (0 for writes/errors)
rsp_last  out  1  high with rsp_valid on final word of transaction
rsp_err  out  1  high with rsp_valid/rsp_last on timeout abort; constant 0 without macro
busy  out  1  high in any state except IDLE
mem_en  out  1  to arbiter: device requests memory
mem_burst_en  out  1  to arbiter: burst read in progress
mem_addr  out  ADDR_W  to arbiter: current word address
mem_di  out  DATA_W  to arbiter: write data
mem_we  out  1  to arbiter: write enable
do_ack  in  1  from arbiter: this device's ack bit
mem_do  in  DATA_W  from arbiter: shared RAM read data

Behaviour:
- Reset values: state IDLE; req_ready=1; every other output 0; remaining count 0. Reset mid-transaction abandons it: no rsp_valid is emitted, and mem_en drops on the next edge.
- All outputs are registered except req_ready and busy, which are decoded from the state register.
- States: IDLE, REQ, GAP.
- IDLE:
  - On req&&req_ready, latch the request, go to REQ.
  - Next cycle: mem_en=1, mem_addr=req_addr, mem_we=req_we, mem_di=req_wdata (0 for reads).
  - mem_burst_en=1 only for reads with effective length > 1.
  - Remaining count = max(req_len,1) for reads, 1 for writes.
- REQ:
  - Hold mem_en, mem_addr, mem_di and mem_we stable until an edge samples do_ack=1.
  - On each such edge, the next cycle has rsp_valid=1 and rsp_data = mem_do sampled at that edge (reads), or 0 (writes). Remaining count decrements.
  - If remaining was 1: next cycle rsp_last=1; mem_en, mem_burst_en and mem_we go to 0; mem_addr and mem_di go to 0; go to GAP.
  - Else: mem_addr += 1, wrapping modulo 2^ADDR_W (0x3FF -> 0x000); mem_en stays 1; stay in REQ.
  - do_ack=1 in IDLE or GAP is ignored (stale ack from a previous grant).
- GAP:
  - Exactly one cycle with mem_en=0, so the arbiter's NO_ONE state and round-robin see a release.
  - Then go to IDLE.
  - req is not accepted in GAP, so the minimum request-to-request spacing is 1 (IDLE) + N acks + 1 (GAP).
- Back-to-back acks on consecutive cycles are legal. Each one produces one rsp_valid, in order, with no gaps required.
- rsp_valid has no backpressure; the core side must always accept.
- req changing while busy has no effect; the latched request is used.

Optional Feature:
- Macro: MEM_CLIENT_TIMEOUT_EN.
- Defined:
  - A counter clears on request accept and on each do_ack, and increments in REQ otherwise.
  - When it reaches TIMEOUT_CYCLES with no ack, the next cycle has rsp_valid=1, rsp_last=1, rsp_err=1, rsp_data=0. Outputs to the arbiter go to 0 and the state goes to GAP.
  - An ack arriving on the same edge the counter hits the limit wins (normal completion, no error).
- Not defined:
  - No counter logic; rsp_err is tied to 0.
  - REQ waits indefinitely.

Test Plan:
- Single read: req, addr=0x010, len=1; ack after 3 cycles with mem_do=0xDEADBEEF -> one rsp_valid+rsp_last with rsp_data=0xDEADBEEF; mem_en high exactly 4 cycles; mem_burst_en=0 throughout; GAP cycle seen.
- Write: req_we=1, addr=0x3FF, wdata=0x12345678, len=7 -> mem_we=1, mem_di=0x12345678, mem_burst_en=0; one rsp (data 0, last=1) after a single ack.
- Burst wrap: read addr=0x3FE, len=4, acks on 4 consecutive cycles -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; four rsp_valid pulses, rsp_last only on the 4th; mem_burst_en high until the last ack.
- Stall and stale ack: do_ack pulsed while IDLE, then a read with ack delayed 10 cycles -> stale ack ignored (no rsp); mem_addr and mem_en stable for all 10 cycles; req raised during busy is not accepted.
- Reset mid-burst: read len=8, assert reset after 3 acks -> the next cycle has mem_en=0, rsp_valid=0, req_ready=1; no further rsp pulses.
- Timeout (macro on, TIMEOUT_CYCLES=64): read with no ack -> after 64 REQ cycles, rsp_valid=rsp_last=rsp_err=1, rsp_data=0, mem_en=0, then IDLE. Repeat with the ack landing on cycle 64 -> rsp_err=0.
